fu_ctrl_sequencer: RTL and testbench

FU_CTRL_SEQUENCER -- requirements
Module: fu_ctrl_sequencer

---
 rtl/fu_ctrl_sequencer.sv | 111 +++++++++++
 tb/tb_fu_ctrl_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fu_ctrl_sequencer.sv
// rtl/fu_ctrl_sequencer.sv - firing/accumulation controller for a functional unit
module fu_ctrl_sequencer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 feedback_i,
  input  logic [CNT_WIDTH-1:0] acc_len_i,
  input  logic                 use_din2_i,
  input  logic                 use_cin_i,
  input  logic                 in1_valid_i,
  input  logic                 in2_valid_i,
  input  logic                 cin_valid_i,
  output logic                 in1_ready_o,
  output logic                 in2_ready_o,
  output logic                 cin_ready_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 fu_en_o,
  output logic                 fu_clr_o,
  output logic [CNT_WIDTH-1:0] iter_cnt_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_RUN    = 2'd1,
    S_FULL   = 2'd2,
    S_RELOAD = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] iter_q, iter_d;
  logic [CNT_WIDTH-1:0] acc_len_q;
  logic [CNT_WIDTH-1:0] term_cnt;
  logic                 req_ok;
  logic                 last_iter;
  logic                 fire;

  // All configured operands present.
  assign req_ok = in1_valid_i & (in2_valid_i | ~use_din2_i) & (cin_valid_i | ~use_cin_i);

  // A zero length behaves like one firing per output; length is sampled so
  // a change only affects comparisons from the following cycle.
  assign term_cnt  = (acc_len_q == '0) ? '0 : acc_len_q - CNT_WIDTH'(1);
  assign last_iter = (iter_q == term_cnt);

  // Next-state, counter and firing decision; clear overrides everything.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    fire    = 1'b0;
    unique case (state_q)
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        fire = req_ok;
        if (fire) begin
          if (feedback_i) begin
            if (last_iter) begin
              state_d = S_FULL;
              iter_d  = '0;
            end else begin
              iter_d = iter_q + CNT_WIDTH'(1);
            end
          end else begin
            state_d = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (feedback_i) begin
          if (out_ready_i) state_d = S_RELOAD;
        end else begin
          fire = req_ok & out_ready_i;
          if (out_ready_i & ~fire) state_d = S_RUN;
        end
      end
      S_RELOAD: state_d = S_INIT;
      default:  state_d = S_INIT;
    endcase
    if (clr_i) begin
      fire    = 1'b0;
      state_d = S_INIT;
      iter_d  = '0;
    end
  end

  // Controller state, accumulation count and sampled length.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_INIT;
      iter_q    <= '0;
      acc_len_q <= '0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      acc_len_q <= acc_len_i;
    end
  end

  assign fu_en_o     = fire;
  assign in1_ready_o = fire;
  assign in2_ready_o = fire & use_din2_i;
  assign cin_ready_o = fire & use_cin_i;
  assign out_valid_o = (state_q == S_FULL);
  assign fu_clr_o    = clr_i | (state_q == S_RELOAD);
  assign iter_cnt_o  = iter_q;
  assign busy_o      = (state_q != S_RUN) | (iter_q != '0);

endmodule

// File: tb/tb_fu_ctrl_sequencer.sv
// tb/tb_fu_ctrl_sequencer.sv - self-checking bench for fu_ctrl_sequencer
module tb_fu_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        fb;
  logic [15:0] acc_len;
  logic        u2, uc;
  logic        v1, v2, cv;
  logic        r1, r2, rc;
  logic        out_valid;
  logic        rdy;
  logic        fu_en, fu_clr;
  logic [15:0] iter;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Model of the controller in terms of bubbles, a held result and a firing count.
  int m_bubble;
  int m_have;
  int m_n;
  int m_len;
  int eff_len;
  int req, take, e_fire, accepted;

  fu_ctrl_sequencer #(.CNT_WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (clr),
    .feedback_i  (fb),
    .acc_len_i   (acc_len),
    .use_din2_i  (u2),
    .use_cin_i   (uc),
    .in1_valid_i (v1),
    .in2_valid_i (v2),
    .cin_valid_i (cv),
    .in1_ready_o (r1),
    .in2_ready_o (r2),
    .cin_ready_o (rc),
    .out_valid_o (out_valid),
    .out_ready_i (rdy),
    .fu_en_o     (fu_en),
    .fu_clr_o    (fu_clr),
    .iter_cnt_o  (iter),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  // Every cycle: compare DUT against the model, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_bubble = 1; m_have = 0; m_n = 0; m_len = 0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_fu_en", int'(fu_en), 0);
      chk("rst_readies", int'({r1, r2, rc}), 0);
      chk("rst_iter", int'(iter), 0);
      chk("rst_fu_clr", int'(fu_clr), int'(clr));
    end else begin
      eff_len = (m_len == 0) ? 1 : m_len;
      req     = int'(v1 & (v2 | ~u2) & (cv | ~uc));
      take    = int'(m_bubble == 0 && (m_have == 0 || (!fb && rdy)));
      e_fire  = int'(!clr && req != 0 && take != 0);
      chk("m_fu_en", int'(fu_en), e_fire);
      chk("m_in1_ready", int'(r1), e_fire);
      chk("m_in2_ready", int'(r2), e_fire & int'(u2));
      chk("m_cin_ready", int'(rc), e_fire & int'(uc));
      chk("m_out_valid", int'(out_valid), m_have);
      chk("m_fu_clr", int'(fu_clr), int'(clr || m_bubble == 2));
      chk("m_iter", int'(iter), m_n);
      chk("m_busy", int'(busy), int'(m_bubble != 0 || m_have != 0 || m_n != 0));
      accepted = int'(m_have != 0 && rdy);
      if (clr) begin
        m_bubble = 1; m_have = 0; m_n = 0;
      end else if (m_bubble > 0) begin
        m_bubble--;
      end else if (fb) begin
        if (accepted != 0) begin
          m_have = 0; m_bubble = 2;
        end else if (e_fire != 0) begin
          m_n++;
          if (m_n == eff_len) begin
            m_n = 0; m_have = 1;
          end
        end
      end else begin
        m_have = int'(e_fire != 0 || (m_have != 0 && !rdy));
      end
      m_len = int'(acc_len);
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; fb = 1'b0; acc_len = 16'd4;
    u2 = 1'b1; uc = 1'b0; v1 = 1'b0; v2 = 1'b0; cv = 1'b0; rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    v1 = 1'b1; v2 = 1'b1; rdy = 1'b1;
    // INIT cycle after reset release
    at_neg; chk("init_no_fire", int'(fu_en), 0); chk("init_out_valid", int'(out_valid), 0);
    // streaming: first fire, then results every cycle
    tick; at_neg; chk("s_fire1", int'(fu_en), 1); chk("s_ov1", int'(out_valid), 0);
    chk("s_in2_ready", int'(r2), 1); chk("s_cin_ready", int'(rc), 0);
    tick; at_neg; chk("s_fire2", int'(fu_en), 1); chk("s_ov2", int'(out_valid), 1);
    // backpressure for three cycles
    tick; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg; chk("bp_fu_en", int'(fu_en), 0); chk("bp_in1_ready", int'(r1), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      tick;
    end
    rdy = 1'b1;
    at_neg; chk("bp_resume", int'(fu_en), 1); chk("bp_ov", int'(out_valid), 1);
    // missing operand 2
    tick; v2 = 1'b0;
    at_neg; chk("miss_fu_en", int'(fu_en), 0); chk("miss_in1_ready", int'(r1), 0);
    tick; at_neg; chk("miss_drain", int'(out_valid), 0);
    tick; u2 = 1'b0;
    at_neg; chk("nodin2_fire", int'(fu_en), 1); chk("nodin2_in2_ready", int'(r2), 0);
    tick; v1 = 1'b0;
    // control input participation
    tick; u2 = 1'b1; v2 = 1'b1; uc = 1'b1; cv = 1'b0; v1 = 1'b1;
    at_neg; chk("cin_missing", int'(fu_en), 0); chk("cin_missing_rdy", int'(rc), 0);
    tick; cv = 1'b1;
    at_neg; chk("cin_fire", int'(rc), 1);
    tick; v1 = 1'b0;
    // accumulate, length 4
    tick; uc = 1'b0; cv = 1'b0; fb = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_neg; chk("acc_fire", int'(fu_en), 1); chk("acc_iter", int'(iter), i);
      chk("acc_ov_low", int'(out_valid), 0);
      tick;
    end
    at_neg; chk("acc_full", int'(out_valid), 1); chk("acc_full_nofire", int'(fu_en), 0);
    chk("acc_iter_wrap", int'(iter), 0);
    tick; at_neg; chk("acc_reload_clr", int'(fu_clr), 1); chk("acc_reload_nofire", int'(fu_en), 0);
    tick; acc_len = 16'd0;
    at_neg; chk("acc_init_clr", int'(fu_clr), 0); chk("acc_init_nofire", int'(fu_en), 0);
    // length 0 behaves as 1
    tick; rdy = 1'b0;
    at_neg; chk("len0_fire", int'(fu_en), 1);
    tick; at_neg; chk("len0_full", int'(out_valid), 1);
    tick; rdy = 1'b1;
    at_neg; chk("len0_hold", int'(out_valid), 1);
    tick; at_neg; chk("len0_reload", int'(fu_clr), 1);
    tick; acc_len = 16'd4; v1 = 1'b0;
    // clear while holding a streaming result
    tick; fb = 1'b0; v1 = 1'b1; rdy = 1'b0;
    at_neg; chk("clr_pre_fire", int'(fu_en), 1);
    tick; at_neg; chk("clr_pre_full", int'(out_valid), 1);
    tick; clr = 1'b1; rdy = 1'b1;
    at_neg; chk("clr_nofire", int'(fu_en), 0); chk("clr_fu_clr", int'(fu_clr), 1);
    chk("clr_in1_ready", int'(r1), 0);
    tick; clr = 1'b0;
    at_neg; chk("clr_init_ov", int'(out_valid), 0); chk("clr_init_fire", int'(fu_en), 0);
    chk("clr_iter", int'(iter), 0);
    tick; at_neg; chk("clr_after_fire", int'(fu_en), 1);
    tick; v1 = 1'b0;
    // reset in the middle of an accumulation
    tick; fb = 1'b1; v1 = 1'b1;
    tick; at_neg; chk("mid_iter", int'(iter), 1);
    tick; rst_n = 1'b0;
    #1;
    chk("arst_iter", int'(iter), 0); chk("arst_ov", int'(out_valid), 0);
    chk("arst_fu_en", int'(fu_en), 0); chk("arst_busy", int'(busy), 1);
    tick; rst_n = 1'b1;
    at_neg; chk("arst_init", int'(fu_en), 0);
    tick; at_neg; chk("arst_refire", int'(fu_en), 1); chk("arst_refire_iter", int'(iter), 0);
    tick; v1 = 1'b0;
    repeat (6) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
